// File: rtl/ga_pkg.sv
// ga_pkg -- shared types and constants for the GA population datapath.
//
// Contents:
//   rd_state_e     : read-engine FSM states (IDLE, RUN, DONE)
//   *_DEF          : default word width, population size and address width
//   FIT_LSB        : bit position of the fitness field in a default-width word
//                    (fitness occupies the top FIT_WDTH bits of each word)
package ga_pkg;

  localparam int DATA_WDTH_DEF = 320;
  localparam int COL_DEF       = 200;
  localparam int COL_BITS_DEF  = 8;
  localparam int FIT_WDTH_DEF  = 16;

  localparam int FIT_LSB = DATA_WDTH_DEF - FIT_WDTH_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/pop_best_tracker.sv
// pop_best_tracker -- running maximum of fitness over one population sweep.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : accepted sweep start; clears the maximum and best_valid
//   upd         : an individual was handed downstream this cycle
//   set         : sweep finishing; best_valid rises together with done
//   fit, addr   : fitness and RAM address of the individual being handed off
//   best_fit    : largest fitness seen so far (unsigned)
//   best_addr   : address of best_fit
//   best_valid  : best_* describe a completed sweep
module pop_best_tracker #(
  parameter int FIT_WDTH = 16,
  parameter int COL_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                upd,
  input  logic                set,
  input  logic [FIT_WDTH-1:0] fit,
  input  logic [COL_BITS-1:0] addr,
  output logic [FIT_WDTH-1:0] best_fit,
  output logic [COL_BITS-1:0] best_addr,
  output logic                best_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_fit   <= '0;
      best_addr  <= '0;
      best_valid <= 1'b0;
    end else begin
      // Strictly-greater compare: on a tie the earlier (lower) address wins,
      // since the sweep visits addresses in ascending order.
      if (clr) begin
        best_fit  <= '0;
        best_addr <= '0;
      end else if (upd && (fit > best_fit)) begin
        best_fit  <= fit;
        best_addr <= addr;
      end
      // A zero-length sweep clears and finishes in the same cycle; finishing wins.
      if (set) begin
        best_valid <= 1'b1;
      end else if (clr) begin
        best_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/population_reader.sv
// population_reader -- sequential read engine for the GA population RAM.
//
// On an accepted start it walks addresses 0..count-1 (count = num clamped to
// COL) through the RAM's asynchronous read port and streams each word out on
// a valid/ready interface. Optionally tracks the fittest individual.
//
// Build option: define POP_READER_BEST_EN to enable the best-fitness tracker;
// otherwise best_fit/best_addr/best_valid are tied to 0.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, num     : sweep request (IDLE only) and individual count
//   busy, done     : sweep in progress / one-cycle completion pulse
//   addrb, doutb   : RAM read address / combinational read data
//   m_data, m_addr : individual and its RAM address
//   m_last         : final individual of the sweep
//   m_valid,m_ready: output handshake
//   best_fit, best_addr, best_valid : fittest individual of the last sweep
module population_reader
  import ga_pkg::*;
#(
  parameter int DATA_WDTH = DATA_WDTH_DEF,
  parameter int COL       = COL_DEF,
  parameter int COL_BITS  = COL_BITS_DEF,
  parameter int FIT_WDTH  = FIT_WDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [COL_BITS:0]    num,
  output logic                 busy,
  output logic                 done,
  output logic [COL_BITS-1:0]  addrb,
  input  logic [DATA_WDTH-1:0] doutb,
  output logic [DATA_WDTH-1:0] m_data,
  output logic [COL_BITS-1:0]  m_addr,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [FIT_WDTH-1:0]  best_fit,
  output logic [COL_BITS-1:0]  best_addr,
  output logic                 best_valid
);

  localparam logic [COL_BITS:0] ColMax = (COL_BITS + 1)'(COL);

  rd_state_e state, state_nxt;

  logic [COL_BITS:0]    count_p0;
  logic [COL_BITS:0]    rd_ptr_p0;
  logic [DATA_WDTH-1:0] data_p1;
  logic [COL_BITS-1:0]  addr_p1;
  logic                 last_p1;
  logic                 vld_p1;
  logic                 done_q;

  logic [COL_BITS:0]    num_clamp;
  logic                 accept;
  logic                 hs;
  logic                 load;
  logic                 fin;

  assign num_clamp = (num > ColMax) ? ColMax : num;
  assign accept    = (state == IDLE) && start;
  assign hs        = vld_p1 && m_ready;
  // The output slot is free when empty or being drained this cycle.
  assign load      = (state == RUN) && (!vld_p1 || m_ready) && (rd_ptr_p0 < count_p0);
  // Sweep ends on the final handshake, or immediately for an empty request.
  assign fin       = ((state == RUN) && hs && last_p1) || (accept && (num == '0));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && (num != '0)) state_nxt = RUN;
      RUN:  if (hs && last_p1)         state_nxt = DONE;
      DONE:                            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // p0: read pointer into the RAM's asynchronous port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_p0  <= '0;
      rd_ptr_p0 <= '0;
    end else if (accept) begin
      count_p0  <= num_clamp;
      rd_ptr_p0 <= '0;
    end else if (load) begin
      rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
    end
  end

  assign addrb = rd_ptr_p0[COL_BITS-1:0];

  // p1: output register, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      addr_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fin;
      if (load) begin
        data_p1 <= doutb;
        addr_p1 <= rd_ptr_p0[COL_BITS-1:0];
        last_p1 <= (rd_ptr_p0 == (count_p0 - 1'b1));
        vld_p1  <= 1'b1;
      end else if (hs) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign m_data  = data_p1;
  assign m_addr  = addr_p1;
  assign m_last  = last_p1;
  assign m_valid = vld_p1;
  assign done    = done_q;

`ifdef POP_READER_BEST_EN
  localparam int FitLsb = DATA_WDTH - FIT_WDTH;

  pop_best_tracker #(
    .FIT_WDTH (FIT_WDTH),
    .COL_BITS (COL_BITS)
  ) u_best (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept),
    .upd        (hs),
    .set        (fin),
    .fit        (data_p1[FitLsb +: FIT_WDTH]),
    .addr       (addr_p1),
    .best_fit   (best_fit),
    .best_addr  (best_addr),
    .best_valid (best_valid)
  );
`else
  assign best_fit   = '0;
  assign best_addr  = '0;
  assign best_valid = 1'b0;
`endif

endmodule

// File: tb/tb_population_reader.sv
// tb_population_reader -- directed bench for population_reader with a
// queue-based reference model and per-cycle output comparison.
module tb_population_reader;

  localparam int DW   = 320;
  localparam int COLN = 200;
  localparam int CB   = 8;
  localparam int FW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CB:0]   num = '0;
  logic          busy, done;
  logic [CB-1:0] addrb;
  logic [DW-1:0] doutb;
  logic [DW-1:0] m_data;
  logic [CB-1:0] m_addr;
  logic          m_last, m_valid;
  logic          m_ready = 1'b0;
  logic [FW-1:0] best_fit;
  logic [CB-1:0] best_addr;
  logic          best_valid;

  logic [DW-1:0] mem [0:255];
  assign doutb = mem[addrb];

  population_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num        (num),
    .busy       (busy),
    .done       (done),
    .addrb      (addrb),
    .doutb      (doutb),
    .m_data     (m_data),
    .m_addr     (m_addr),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .best_fit   (best_fit),
    .best_addr  (best_addr),
    .best_valid (best_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state
  int            q[$];
  int            cur_cnt = 0;
  bit            pend_done = 0;
  bit            chk_en = 0;
  int            hs_count = 0;
  int            last_hs_addr = -1;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [CB-1:0] prev_addr;
  logic          prev_last;
  bit            mbv = 0;
  int            mbest = 0;
  int            mbaddr = 0;
  int            n_cyc = 0;

  function automatic int fit_of(input int a);
    logic [DW-1:0] w;
    w = mem[a];
    return int'(w[DW-1 -: FW]);
  endfunction

  task automatic model_clear();
    q.delete();
    pend_done = 0;
    prev_stall = 0;
    mbv = 0;
    mbest = 0;
    mbaddr = 0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_d;
      int a;
      exp_d = pend_done;
      pend_done = 0;
      if (exp_d) mbv = 1;
      chk("done", DW'(done), DW'(exp_d));
`ifdef POP_READER_BEST_EN
      chk("best_valid", DW'(best_valid), DW'(mbv));
      if (mbv) begin
        chk("best_fit", DW'(best_fit), DW'(mbest));
        chk("best_addr", DW'(best_addr), DW'(mbaddr));
      end
`else
      chk("best_zero", DW'({best_valid, best_fit, best_addr}), '0);
`endif
      if (m_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", DW'(m_valid), '0);
        end else begin
          a = q[0];
          chk("m_addr", DW'(m_addr), DW'(a));
          chk("m_data", m_data, mem[a]);
          chk("m_last", DW'(m_last), DW'(a == cur_cnt - 1));
        end
        if (prev_stall) begin
          chk("stall_hold", DW'({m_addr, m_last}), DW'({prev_addr, prev_last}));
          chk("stall_data", m_data, prev_data);
        end
      end else if (prev_stall) begin
        chk("valid_dropped", DW'(m_valid), DW'(1));
      end
      if (m_valid && m_ready && q.size() > 0) begin
        a = q.pop_front();
        hs_count++;
        last_hs_addr = a;
        if (fit_of(a) > mbest) begin
          mbest = fit_of(a);
          mbaddr = a;
        end
        if (a == cur_cnt - 1) pend_done = 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_addr = m_addr;
      prev_last = m_last;
    end
  end

  // Drive an accepted start; returns just after the accepting edge (cycle N+1).
  task automatic do_start(input int n);
    @(posedge clk);
    #1 start = 1'b1;
    num = (CB + 1)'(n);
    @(posedge clk);
    #1 start = 1'b0;
    num = 9'd7;
    n_cyc = cyc - 1;
    cur_cnt = (n > COLN) ? COLN : n;
    q.delete();
    for (int i = 0; i < cur_cnt; i++) q.push_back(i);
    hs_count = 0;
    last_hs_addr = -1;
    mbv = 0;
    mbest = 0;
    mbaddr = 0;
    if (cur_cnt == 0) pend_done = 1;
  endtask

  task automatic wait_done(input int budget, output int lat);
    bit seen;
    seen = 0;
    lat = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        lat = cyc - n_cyc;
      end
    end
    if (!seen) chk("done_timeout", '0, DW'(1));
  endtask

  initial begin
    int lat;
    bit seen;
    bit pat[4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

    for (int a = 0; a < 256; a++) begin
      mem[a] = '0;
      mem[a][15:0] = 16'(a + 100);
      mem[a][DW-1 -: FW] = FW'((a * 7) % 50);
    end
    mem[0][DW-1 -: FW] = 16'd5;
    mem[1][DW-1 -: FW] = 16'd9;
    mem[2][DW-1 -: FW] = 16'd9;
    mem[3][DW-1 -: FW] = 16'd3;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_done", DW'(done), '0);
    chk("rst_valid", DW'(m_valid), '0);
    chk("rst_last", DW'(m_last), '0);
    chk("rst_data", m_data, '0);
    chk("rst_maddr", DW'(m_addr), '0);
    chk("rst_addrb", DW'(addrb), '0);
    chk("rst_best", DW'({best_valid, best_fit, best_addr}), '0);
    rst_n = 1'b1;
    #1 chk_en = 1;

    // num=4, ready held high: latency pinned with literals
    m_ready = 1'b1;
    do_start(4);
    @(negedge clk);
    chk("n1_busy", DW'(busy), DW'(1));
    chk("n1_addrb", DW'(addrb), '0);
    chk("n1_valid", DW'(m_valid), '0);
    @(negedge clk);
    chk("n2_valid", DW'(m_valid), DW'(1));
    chk("n2_addr", DW'(m_addr), '0);
    chk("n2_word", DW'(m_data[15:0]), DW'(100));
    chk("n2_fit", DW'(m_data[DW-1 -: FW]), DW'(5));
    wait_done(20, lat);
    chk("done_latency", DW'(lat), DW'(6));
    chk("done_busy", DW'(busy), '0);
    chk("last_addr4", DW'(last_hs_addr), DW'(3));
    chk("hs_count4", DW'(hs_count), DW'(4));
`ifdef POP_READER_BEST_EN
    chk("lit_best_fit", DW'(best_fit), DW'(9));
    chk("lit_best_addr", DW'(best_addr), DW'(1));
    chk("lit_best_valid", DW'(best_valid), DW'(1));
`else
    chk("lit_best_off", DW'({best_valid, best_fit, best_addr}), '0);
`endif
    repeat (2) @(posedge clk);

    // num=4 with ready toggling 1,0,0,1,...
    m_ready = 1'b0;
    do_start(4);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      m_ready = pat[i % 4];
      @(negedge clk);
      if (done) seen = 1;
      @(posedge clk);
      #1;
    end
    chk("stall_done_seen", DW'(seen), DW'(1));
    chk("stall_hs_count", DW'(hs_count), DW'(4));
    chk("stall_q_empty", DW'(q.size()), '0);
    m_ready = 1'b1;
    repeat (2) @(posedge clk);

    // num=0: single done pulse, no data
    do_start(0);
    @(negedge clk);
    chk("zero_done", DW'(done), DW'(1));
    chk("zero_valid", DW'(m_valid), '0);
    @(negedge clk);
    chk("zero_done_off", DW'(done), '0);
    chk("zero_hs", DW'(hs_count), '0);
    repeat (2) @(posedge clk);

    // num=250 clamps to 200
    do_start(250);
    wait_done(400, lat);
    chk("clamp_hs_count", DW'(hs_count), DW'(200));
    chk("clamp_last_addr", DW'(last_hs_addr), DW'(199));
    chk("clamp_latency", DW'(lat), DW'(202));
    repeat (2) @(posedge clk);

    // start pulsed again during RUN is ignored
    do_start(6);
    @(posedge clk);
    #1 start = 1'b1;
    num = 9'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(30, lat);
    chk("ignore_hs_count", DW'(hs_count), DW'(6));
    chk("ignore_latency", DW'(lat), DW'(8));
    repeat (2) @(posedge clk);

    // Reset at the third handshake of a num=10 sweep
    do_start(10);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_valid && m_addr == 8'd2) seen = 1;
    end
    chk("abort_reached", DW'(seen), DW'(1));
    #1 chk_en = 0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", DW'(busy), '0);
    chk("abort_done", DW'(done), '0);
    chk("abort_valid", DW'(m_valid), '0);
    chk("abort_last", DW'(m_last), '0);
    chk("abort_data", m_data, '0);
    chk("abort_maddr", DW'(m_addr), '0);
    chk("abort_addrb", DW'(addrb), '0);
    chk("abort_best", DW'({best_valid, best_fit, best_addr}), '0);
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_en = 1;
    repeat (6) @(negedge clk);

    // Fresh sweep after the abort starts from address 0
    do_start(3);
    @(negedge clk);
    chk("restart_busy", DW'(busy), DW'(1));
    @(negedge clk);
    chk("restart_addr", DW'(m_addr), '0);
    wait_done(20, lat);
    chk("restart_hs", DW'(hs_count), DW'(3));
    chk("restart_latency", DW'(lat), DW'(5));
    repeat (3) @(posedge clk);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
